fetch_stage: RTL and testbench

Dual-issue instruction fetch stage that feeds the IF/ID pipeline register. Holds the fetch PC and issues one request per instruction pair (slot 0 at PC, slot 1 at PC+4) to the instruction cache, tracking at most one outstanding request. A single-entry pair buffer absorbs hazard-unit stalls. Redirects from EX override everything and discard wrong-path responses.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_pair_buf.sv | 65 ++++++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] PAIR_STRIDE = 32'd8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage and the cache.
interface fetch_stage_if;

  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_req_ready;
  logic        ic_rvalid;
  logic [31:0] ic_rdata_a;
  logic [31:0] ic_rdata_b;

  modport master (
    output ic_req,
    output ic_addr,
    input  ic_req_ready,
    input  ic_rvalid,
    input  ic_rdata_a,
    input  ic_rdata_b
  );

  modport slave (
    input  ic_req,
    input  ic_addr,
    output ic_req_ready,
    output ic_rvalid,
    output ic_rdata_a,
    output ic_rdata_b
  );

endinterface

// File: rtl/fetch_pair_buf.sv
// Single-entry instruction-pair register feeding IF/ID; shows a NOP pair when empty.
module fetch_pair_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  fetch_pair_t pair_i,
  output logic        valid_o,
  output logic [31:0] pcf0_o,
  output logic [31:0] pcplus4f0_o,
  output logic [31:0] pcf1_o,
  output logic [31:0] pcplus4f1_o,
  output logic [31:0] instr_a_o,
  output logic [31:0] instr_b_o
);

  logic        valid_q, valid_d;
  fetch_pair_t pair_q, pair_d;

  // Clear beats load beats drain; otherwise the pair holds.
  always_comb begin
    valid_d = valid_q;
    pair_d  = pair_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pair_d  = pair_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pair_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pair_q  <= pair_d;
    end
  end

  always_comb begin
    valid_o     = valid_q;
    pcf0_o      = 32'd0;
    pcplus4f0_o = 32'd0;
    pcf1_o      = 32'd0;
    pcplus4f1_o = 32'd0;
    instr_a_o   = NOP_INSTR;
    instr_b_o   = NOP_INSTR;
    if (valid_q) begin
      pcf0_o      = pair_q.pc;
      pcplus4f0_o = pair_q.pc + 32'd4;
      pcf1_o      = pair_q.pc + 32'd4;
      pcplus4f1_o = pair_q.pc + 32'd8;
      instr_a_o   = pair_q.a;
      instr_b_o   = pair_q.b;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Dual-issue fetch: one cache request per instruction pair, one outstanding at most,
// redirects squash the in-flight request and any pair already buffered.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          StallF,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master ic,
  output logic [31:0]   PCF_0,
  output logic [31:0]   PCPlus4F_0,
  output logic [31:0]   PCF_1,
  output logic [31:0]   PCPlus4F_1,
  output logic [31:0]   instrF_a,
  output logic [31:0]   instrF_b,
  output logic          fetch_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         req;
  logic         handshake;
  logic         buf_valid;
  logic         buf_load;
  logic         buf_clear;
  logic         buf_drain;
  fetch_pair_t  load_pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // A redirect with the response still in flight must swallow that response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) state_d = WAIT;
      end
      WAIT, DROP: begin
        if (redirect && !ic.ic_rvalid) state_d = DROP;
        else if (handshake)            state_d = WAIT;
        else if (ic.ic_rvalid)         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req       = !redirect && (state_q == IDLE || ic.ic_rvalid) && (!buf_valid || !StallF);
    handshake = req && ic.ic_req_ready;
    buf_clear = redirect;
    buf_load  = (state_q == WAIT) && ic.ic_rvalid;
    buf_drain = !StallF;
  end

  // req_pc_q remembers which pair the outstanding response belongs to.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect) begin
      pc_d = redirect_pc & ~32'd3;
    end else if (handshake) begin
      pc_d     = pc_q + PAIR_STRIDE;
      req_pc_d = pc_q;
    end
  end

  assign ic.ic_req  = req;
  assign ic.ic_addr = pc_q;

  assign load_pair = '{pc: req_pc_q, a: ic.ic_rdata_a, b: ic.ic_rdata_b};

  fetch_pair_buf u_pair_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (buf_clear),
    .load_i     (buf_load),
    .drain_i    (buf_drain),
    .pair_i     (load_pair),
    .valid_o    (buf_valid),
    .pcf0_o     (PCF_0),
    .pcplus4f0_o(PCPlus4F_0),
    .pcf1_o     (PCF_1),
    .pcplus4f1_o(PCPlus4F_1),
    .instr_a_o  (instrF_a),
    .instr_b_o  (instrF_b)
  );

  assign fetch_valid = buf_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a pair-level reference model and a simple cache responder.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] PCF_0, PCPlus4F_0, PCF_1, PCPlus4F_1, instrF_a, instrF_b;
  logic        fetch_valid;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ic         (bus),
    .PCF_0      (PCF_0),
    .PCPlus4F_0 (PCPlus4F_0),
    .PCF_1      (PCF_1),
    .PCPlus4F_1 (PCPlus4F_1),
    .instrF_a   (instrF_a),
    .instrF_b   (instrF_b),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // cache responder state
  bit          c_pend = 1'b0;
  int          c_cnt  = 0;
  logic [31:0] c_addr = 32'd0;

  // reference model: expected fetch pc, outstanding/live request, buffered pair
  bit          m_outst = 1'b0;
  bit          m_live  = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_req = 32'd0;
  logic [31:0] m_bpc = 32'd0;
  logic [31:0] m_a   = 32'd0;
  logic [31:0] m_b   = 32'd0;

  logic         o_req, o_hs, e_req;
  logic [31:0]  o_addr, e_addr;
  logic [192:0] o_out, e_out;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic model_reset();
    m_pc    = RST_PC;
    m_valid = 1'b0;
    m_outst = 1'b0;
    m_live  = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, then advance models.
  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc,
                      input logic ready, input int lat);
    logic rv;
    logic e_hs;
    @(negedge clk);
    rv = c_pend && (c_cnt == 0);
    StallF           = stall;
    redirect         = redir;
    redirect_pc      = rpc;
    bus.ic_req_ready = ready;
    bus.ic_rvalid    = rv;
    bus.ic_rdata_a   = rv ? mem_word(c_addr) : 32'hDEAD_BEEF;
    bus.ic_rdata_b   = rv ? mem_word(c_addr + 32'd4) : 32'hDEAD_BEEF;
    #1;
    o_req  = bus.ic_req;
    o_addr = bus.ic_addr;
    o_hs   = o_req && ready;
    o_out  = {fetch_valid, PCF_0, PCPlus4F_0, PCF_1, PCPlus4F_1, instrF_a, instrF_b};

    e_req  = !redir && (!m_outst || rv) && (!m_valid || !stall);
    e_addr = m_pc;
    e_hs   = e_req && ready;
    if (m_valid)
      e_out = {1'b1, m_bpc, m_bpc + 32'd4, m_bpc + 32'd4, m_bpc + 32'd8, m_a, m_b};
    else
      e_out = {1'b0, 32'd0, 32'd0, 32'd0, 32'd0, NOP, NOP};

    if (rv) c_pend = 1'b0;
    else if (c_pend && c_cnt > 0) c_cnt--;
    if (o_hs) begin
      c_pend = 1'b1;
      c_addr = o_addr;
      c_cnt  = lat - 1;
      $display("req addr=%h stall=%0d redirect=%0d rvalid=%0d valid=%0d pc0=%h",
               o_addr, stall, redir, rv, fetch_valid, PCF_0);
    end

    if (redir) m_valid = 1'b0;
    else if (rv && m_outst && m_live) begin
      m_valid = 1'b1;
      m_bpc   = m_req;
      m_a     = mem_word(m_req);
      m_b     = mem_word(m_req + 32'd4);
    end else if (!stall) m_valid = 1'b0;
    if (rv) m_outst = 1'b0;
    if (redir) m_live = 1'b0;
    if (e_hs) begin
      m_outst = 1'b1;
      m_live  = 1'b1;
      m_req   = m_pc;
    end
    if (redir) m_pc = {rpc[31:2], 2'b00};
    else if (e_hs) m_pc = m_pc + 32'd8;
  endtask

  task automatic do_reset();
    @(negedge clk);
    redirect = 1'b0; StallF = 1'b0; bus.ic_rvalid = 1'b0; bus.ic_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    c_pend = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.ic_req_ready = 1'b0; bus.ic_rvalid = 1'b0;
    bus.ic_rdata_a = 32'd0; bus.ic_rdata_b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", fetch_valid); end
    total++; if (instrF_a !== NOP || instrF_b !== NOP) begin bad++; $display("FAIL rst_nop got %h/%h want %h", instrF_a, instrF_b, NOP); end
    total++; if (PCF_0 !== 32'd0 || PCPlus4F_1 !== 32'd0) begin bad++; $display("FAIL rst_pc got %h/%h want 0", PCF_0, PCPlus4F_1); end
    total++; if (bus.ic_addr !== RST_PC) begin bad++; $display("FAIL rst_addr got %h want %h", bus.ic_addr, RST_PC); end
    model_reset();
    c_pend = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_throughput();
    step(0, 0, 0, 1, 1);
    total++; if (o_req !== 1'b1 || o_addr !== 32'h100) begin bad++; $display("FAIL thr_req0 got %b/%h want 1/100", o_req, o_addr); end
    step(0, 0, 0, 1, 1);
    total++; if (o_hs !== 1'b1 || o_addr !== 32'h108) begin bad++; $display("FAIL thr_req1 got %b/%h want 1/108", o_hs, o_addr); end
    step(0, 0, 0, 1, 1);
    total++; if (o_hs !== 1'b1 || o_addr !== 32'h110) begin bad++; $display("FAIL thr_req2 got %b/%h want 1/110", o_hs, o_addr); end
    total++; if (PCF_0 !== 32'h100 || PCPlus4F_1 !== 32'h108) begin bad++; $display("FAIL thr_pair0 got %h/%h want 100/108", PCF_0, PCPlus4F_1); end
    total++; if (instrF_a !== mem_word(32'h100) || instrF_b !== mem_word(32'h104)) begin bad++; $display("FAIL thr_instr0 got %h/%h want %h/%h", instrF_a, instrF_b, mem_word(32'h100), mem_word(32'h104)); end
    step(0, 0, 0, 1, 1);
    total++; if (PCF_0 !== 32'h108 || o_addr !== 32'h118) begin bad++; $display("FAIL thr_pair1 got %h/%h want 108/118", PCF_0, o_addr); end
  endtask

  task automatic test_stall();
    step(0, 0, 0, 0, 1);
    total++; if (PCF_0 !== 32'h110) begin bad++; $display("FAIL stall_pre got %h want 110", PCF_0); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1);
      total++; if (o_req !== 1'b0 || fetch_valid !== 1'b1 || PCF_0 !== 32'h118 || instrF_a !== mem_word(32'h118)) begin
        bad++; $display("FAIL stall_hold%0d got req=%b valid=%b pc=%h want req=0 valid=1 pc=118", i, o_req, fetch_valid, PCF_0);
      end
    end
    step(0, 0, 0, 1, 1);
    total++; if (o_hs !== 1'b1 || o_addr !== 32'h120) begin bad++; $display("FAIL stall_resume got %b/%h want 1/120", o_hs, o_addr); end
    step(0, 0, 0, 0, 1);
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got %b want 0", fetch_valid); end
    step(0, 0, 0, 0, 1);
    total++; if (PCF_0 !== 32'h120 || fetch_valid !== 1'b1) begin bad++; $display("FAIL stall_next got %h/%b want 120/1", PCF_0, fetch_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step(0, 0, 0, 1, 4);
    step(0, 1, 32'h2002, 1, 1);
    total++; if (o_req !== 1'b0) begin bad++; $display("FAIL rdw_redir_req got %b want 0", o_req); end
    step(0, 0, 0, 1, 1);
    total++; if (o_req !== 1'b0 || o_addr !== 32'h2000) begin bad++; $display("FAIL rdw_drop1 got %b/%h want 0/2000", o_req, o_addr); end
    step(0, 0, 0, 1, 1);
    total++; if (o_req !== 1'b0) begin bad++; $display("FAIL rdw_drop2 got %b want 0", o_req); end
    step(0, 0, 0, 1, 1);
    total++; if (o_hs !== 1'b1 || o_addr !== 32'h2000 || fetch_valid !== 1'b0) begin
      bad++; $display("FAIL rdw_late got hs=%b addr=%h valid=%b want 1/2000/0", o_hs, o_addr, fetch_valid);
    end
    step(0, 0, 0, 1, 1);
    total++; if (fetch_valid !== 1'b0 || instrF_a !== NOP) begin bad++; $display("FAIL rdw_discard got %b/%h want 0/%h", fetch_valid, instrF_a, NOP); end
    step(0, 0, 0, 0, 1);
    total++; if (PCF_0 !== 32'h2000 || instrF_a !== mem_word(32'h2000)) begin bad++; $display("FAIL rdw_target got %h/%h want 2000/%h", PCF_0, instrF_a, mem_word(32'h2000)); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h3000, 1, 1);
    total++; if (o_req !== 1'b0) begin bad++; $display("FAIL rdr_req got %b want 0", o_req); end
    step(0, 0, 0, 1, 1);
    total++; if (o_hs !== 1'b1 || o_addr !== 32'h3000 || fetch_valid !== 1'b0) begin
      bad++; $display("FAIL rdr_target got hs=%b addr=%h valid=%b want 1/3000/0", o_hs, o_addr, fetch_valid);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    total++; if (PCF_0 !== 32'h3000) begin bad++; $display("FAIL rdr_pair got %h want 3000", PCF_0); end
  endtask

  task automatic test_ready_low();
    do_reset();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      total++; if (o_req !== 1'b1 || o_addr !== 32'h108) begin bad++; $display("FAIL rdy_hold%0d got %b/%h want 1/108", i, o_req, o_addr); end
      if (i == 0) begin
        total++; if (PCF_0 !== 32'h100) begin bad++; $display("FAIL rdy_pair got %h want 100", PCF_0); end
      end else begin
        total++; if (fetch_valid !== 1'b0 || instrF_b !== NOP) begin bad++; $display("FAIL rdy_nop%0d got %b/%h want 0/%h", i, fetch_valid, instrF_b, NOP); end
      end
    end
    step(0, 0, 0, 1, 1);
    total++; if (o_hs !== 1'b1 || o_addr !== 32'h108) begin bad++; $display("FAIL rdy_accept got %b/%h want 1/108", o_hs, o_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(0, 1, 32'hFFFF_FFF8, 1, 1);
    step(0, 0, 0, 1, 1);
    total++; if (o_hs !== 1'b1 || o_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_req got %b/%h want 1/fffffff8", o_hs, o_addr); end
    step(0, 0, 0, 1, 1);
    total++; if (o_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got %h want 0", o_addr); end
    step(0, 0, 0, 0, 1);
    total++; if (PCF_0 !== 32'hFFFF_FFF8 || PCPlus4F_0 !== 32'hFFFF_FFFC || PCF_1 !== 32'hFFFF_FFFC || PCPlus4F_1 !== 32'h0) begin
      bad++; $display("FAIL wrap_pcs got %h/%h/%h/%h want fffffff8/fffffffc/fffffffc/0", PCF_0, PCPlus4F_0, PCF_1, PCPlus4F_1);
    end
    total++; if (instrF_b !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_instr got %h want %h", instrF_b, mem_word(32'hFFFF_FFFC)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 3);
    total++; if (o_req !== 1'b0 || o_addr !== 32'h108) begin bad++; $display("FAIL rmid_wait got %b/%h want 0/108", o_req, o_addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.ic_addr !== RST_PC || fetch_valid !== 1'b0) begin bad++; $display("FAIL rmid_async got %h/%b want %h/0", bus.ic_addr, fetch_valid, RST_PC); end
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    total++; if (o_req !== 1'b1 || o_addr !== RST_PC) begin bad++; $display("FAIL rmid_first got %b/%h want 1/%h", o_req, o_addr, RST_PC); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    total++; if (fetch_valid !== 1'b0 || o_hs !== 1'b1) begin bad++; $display("FAIL rmid_late got valid=%b hs=%b want 0/1", fetch_valid, o_hs); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    total++; if (PCF_0 !== RST_PC || fetch_valid !== 1'b1) begin bad++; $display("FAIL rmid_pair got %h/%b want %h/1", PCF_0, fetch_valid, RST_PC); end
  endtask

  task automatic test_random();
    logic        st, rd, ry;
    logic [31:0] tgt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      ry  = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      step(st, rd, tgt, ry, $urandom_range(1, 3));
      total++; if (o_req !== e_req) begin bad++; $display("FAIL rnd_req n=%0d got %b want %b", n, o_req, e_req); end
      total++; if (o_addr !== e_addr) begin bad++; $display("FAIL rnd_addr n=%0d got %h want %h", n, o_addr, e_addr); end
      total++; if (o_out !== e_out) begin bad++; $display("FAIL rnd_out n=%0d got %h want %h", n, o_out, e_out); end
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_ready_low();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
